trace_dispatch: RTL and testbench

Synthesizable trace-command dispatcher for the cache simulator. Accepts one decoded trace record per handshake (command number plus address), splits the address into tag/index/offset, and routes it to the data-cache or instruction-cache channel. It holds per-channel read/write/hit/miss counters, handles the clear (8) and print (9) commands in hardware, and streams statistics out on a dump port. It sits between the trace source and the two cache models.

---
 rtl/trace_dispatch_if.sv | 61 ++++++
 rtl/trace_dispatch.sv | 145 ++++++++++++++
 tb/tb_trace_dispatch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_dispatch_if.sv
// Trace dispatcher bus bundle: trace input, both cache channels, clear and dump.
interface trace_dispatch_if #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int CNT_W       = 32
);
  localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;

  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             in_cmd;
  logic [ADDR_W-1:0]      in_addr;

  logic                   d_req_valid;
  logic                   d_req_ready;
  logic [3:0]             d_req_cmd;
  logic [TAG_BITS-1:0]    d_req_tag;
  logic [INDEX_BITS-1:0]  d_req_index;
  logic [OFFSET_BITS-1:0] d_req_offset;
  logic                   d_rsp_valid;
  logic                   d_rsp_hit;

  logic                   i_req_valid;
  logic                   i_req_ready;
  logic [TAG_BITS-1:0]    i_req_tag;
  logic [INDEX_BITS-1:0]  i_req_index;
  logic [OFFSET_BITS-1:0] i_req_offset;
  logic                   i_rsp_valid;
  logic                   i_rsp_hit;

  logic                   cache_clr;
  logic                   dump_valid;
  logic                   dump_ready;
  logic [2:0]             dump_sel;
  logic [CNT_W-1:0]       dump_data;

  // dispatcher side
  modport master (
    input  in_valid, in_cmd, in_addr,
    output in_ready,
    output d_req_valid, d_req_cmd, d_req_tag, d_req_index, d_req_offset,
    input  d_req_ready, d_rsp_valid, d_rsp_hit,
    output i_req_valid, i_req_tag, i_req_index, i_req_offset,
    input  i_req_ready, i_rsp_valid, i_rsp_hit,
    output cache_clr, dump_valid, dump_sel, dump_data,
    input  dump_ready
  );

  // trace source / cache model side
  modport slave (
    output in_valid, in_cmd, in_addr,
    input  in_ready,
    input  d_req_valid, d_req_cmd, d_req_tag, d_req_index, d_req_offset,
    output d_req_ready, d_rsp_valid, d_rsp_hit,
    input  i_req_valid, i_req_tag, i_req_index, i_req_offset,
    output i_req_ready, i_rsp_valid, i_rsp_hit,
    input  cache_clr, dump_valid, dump_sel, dump_data,
    output dump_ready
  );
endinterface

// File: rtl/trace_dispatch.sv
// Trace-command dispatcher: routes one decoded record at a time to the data or
// instruction cache, keeps saturating hit/miss statistics, and handles the
// clear and print commands locally.
module trace_dispatch #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  trace_dispatch_if.master bus
);
  localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // counter slots, in dump order
  localparam int C_DRD = 0, C_DWR = 1, C_DHIT = 2, C_DMISS = 3;
  localparam int C_IRD = 4, C_IHIT = 5, C_IMISS = 6, C_ERR = 7;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, CLEAR, DUMP} state_t;

  state_t            state;
  logic [3:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        sel_q;
  logic [CNT_W-1:0]  cnt [8];
  logic              in_ready_q, d_vld_q, i_vld_q, clr_q, dump_vld_q;

  logic is_i, req_fire, rsp_fire, rsp_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // channel selection follows the latched command; only cmd 2 uses the I side
  always_comb begin
    is_i     = (cmd_q == 4'd2);
    req_fire = is_i ? (i_vld_q & bus.i_req_ready) : (d_vld_q & bus.d_req_ready);
    rsp_fire = is_i ? bus.i_rsp_valid : bus.d_rsp_valid;
    rsp_hit  = is_i ? bus.i_rsp_hit   : bus.d_rsp_hit;
  end

  // dispatcher FSM, registered handshake outputs and statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      sel_q      <= '0;
      in_ready_q <= 1'b1;
      d_vld_q    <= 1'b0;
      i_vld_q    <= 1'b0;
      clr_q      <= 1'b0;
      dump_vld_q <= 1'b0;
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else begin
      clr_q <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          cmd_q  <= bus.in_cmd;
          addr_q <= bus.in_addr;
          if (bus.in_cmd <= 4'd6) begin
            state      <= ISSUE;
            in_ready_q <= 1'b0;
            if (bus.in_cmd == 4'd2) i_vld_q <= 1'b1;
            else                    d_vld_q <= 1'b1;
          end else if (bus.in_cmd == 4'd8) begin
            state      <= CLEAR;
            in_ready_q <= 1'b0;
            clr_q      <= 1'b1;
          end else if (bus.in_cmd == 4'd9) begin
            state      <= DUMP;
            in_ready_q <= 1'b0;
            dump_vld_q <= 1'b1;
            sel_q      <= '0;
          end else begin
            // invalid command: consumed in place, only counted
            cnt[C_ERR] <= sat_inc(cnt[C_ERR]);
          end
        end
        ISSUE: if (req_fire) begin
          d_vld_q <= 1'b0;
          i_vld_q <= 1'b0;
          state   <= WAIT_RSP;
        end
        WAIT_RSP: if (rsp_fire) begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
          case (cmd_q)
            4'd0: begin
              cnt[C_DRD] <= sat_inc(cnt[C_DRD]);
              if (rsp_hit) cnt[C_DHIT]  <= sat_inc(cnt[C_DHIT]);
              else         cnt[C_DMISS] <= sat_inc(cnt[C_DMISS]);
            end
            4'd1: begin
              cnt[C_DWR] <= sat_inc(cnt[C_DWR]);
              if (rsp_hit) cnt[C_DHIT]  <= sat_inc(cnt[C_DHIT]);
              else         cnt[C_DMISS] <= sat_inc(cnt[C_DMISS]);
            end
            4'd2: begin
              cnt[C_IRD] <= sat_inc(cnt[C_IRD]);
              if (rsp_hit) cnt[C_IHIT]  <= sat_inc(cnt[C_IHIT]);
              else         cnt[C_IMISS] <= sat_inc(cnt[C_IMISS]);
            end
            default: ; // snoops complete without touching statistics
          endcase
        end
        CLEAR: begin
          for (int k = 0; k < 8; k++) cnt[k] <= '0;
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
        DUMP: if (bus.dump_ready) begin
          if (sel_q == 3'd7) begin
            dump_vld_q <= 1'b0;
            sel_q      <= '0;
            state      <= IDLE;
            in_ready_q <= 1'b1;
          end else begin
            sel_q <= sel_q + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.d_req_valid  = d_vld_q;
  assign bus.d_req_cmd    = cmd_q;
  assign bus.d_req_tag    = addr_q[ADDR_W-1 -: TAG_BITS];
  assign bus.d_req_index  = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign bus.d_req_offset = addr_q[OFFSET_BITS-1:0];
  assign bus.i_req_valid  = i_vld_q;
  assign bus.i_req_tag    = addr_q[ADDR_W-1 -: TAG_BITS];
  assign bus.i_req_index  = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign bus.i_req_offset = addr_q[OFFSET_BITS-1:0];
  assign bus.cache_clr    = clr_q;
  assign bus.dump_valid   = dump_vld_q;
  assign bus.dump_sel     = sel_q;
  // counters are live during DUMP; nothing can update them in that state
  assign bus.dump_data    = dump_vld_q ? cnt[sel_q] : '0;

endmodule

// File: tb/tb_trace_dispatch.sv
// Bench for trace_dispatch: a wide-counter and a 3-bit-counter instance share
// the same stimulus; a command-level statistics model predicts dump contents.
module tb_trace_dispatch;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 0, d_req_ready = 0, d_rsp_valid = 0, d_rsp_hit = 0;
  logic        i_req_ready = 0, i_rsp_valid = 0, i_rsp_hit = 0, dump_ready = 0;
  logic [3:0]  in_cmd = 0;
  logic [31:0] in_addr = 0;

  trace_dispatch_if #(.CNT_W(32)) b ();
  trace_dispatch_if #(.CNT_W(3))  b3 ();

  assign b.in_valid  = in_valid;    assign b3.in_valid  = in_valid;
  assign b.in_cmd    = in_cmd;      assign b3.in_cmd    = in_cmd;
  assign b.in_addr   = in_addr;     assign b3.in_addr   = in_addr;
  assign b.d_req_ready = d_req_ready; assign b3.d_req_ready = d_req_ready;
  assign b.d_rsp_valid = d_rsp_valid; assign b3.d_rsp_valid = d_rsp_valid;
  assign b.d_rsp_hit   = d_rsp_hit;   assign b3.d_rsp_hit   = d_rsp_hit;
  assign b.i_req_ready = i_req_ready; assign b3.i_req_ready = i_req_ready;
  assign b.i_rsp_valid = i_rsp_valid; assign b3.i_rsp_valid = i_rsp_valid;
  assign b.i_rsp_hit   = i_rsp_hit;   assign b3.i_rsp_hit   = i_rsp_hit;
  assign b.dump_ready  = dump_ready;  assign b3.dump_ready  = dump_ready;

  trace_dispatch #(.CNT_W(32)) u0 (.clk(clk), .rst_n(rst_n), .bus(b));
  trace_dispatch #(.CNT_W(3))  u1 (.clk(clk), .rst_n(rst_n), .bus(b3));

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [11:0] tag;
    logic [13:0] idx;
    logic [5:0]  off;
    bit          hit;
    int          rdy_lat;
    int          rsp_lat;
    bit          spur;
    bit          tog;
  } vec_t;

  int    tests = 0, fails = 0;
  // true event counts; a W-bit counter must read min(count, 2^W-1)
  longint m [8];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx = (64'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) m[k] = 0;
  endtask

  task automatic chk_req(input vec_t v);
    bit ich = (v.cmd == 4'd2);
    check("req_valid_sel", ich ? b.i_req_valid : b.d_req_valid, 1);
    check("req_valid_oth", ich ? b.d_req_valid : b.i_req_valid, 0);
    check("req_valid_w3",  ich ? b3.i_req_valid : b3.d_req_valid, 1);
    if (ich) begin
      check("i_tag", b.i_req_tag, v.tag);
      check("i_index", b.i_req_index, v.idx);
      check("i_offset", b.i_req_offset, v.off);
    end else begin
      check("d_cmd", b.d_req_cmd, v.cmd);
      check("d_tag", b.d_req_tag, v.tag);
      check("d_index", b.d_req_index, v.idx);
      check("d_offset", b.d_req_offset, v.off);
    end
  endtask

  task automatic dump(input bit tog);
    for (int k = 0; k < 8; k++) begin
      if (tog) begin
        dump_ready = 0;
        check("dump_valid_hold", b.dump_valid, 1);
        check("dump_sel_hold", b.dump_sel, k);
        check("dump_data_hold", b.dump_data, sat(m[k], 32));
        step();
      end
      dump_ready = 1;
      check("dump_valid", b.dump_valid, 1);
      check("dump_valid_w3", b3.dump_valid, 1);
      check("dump_sel", b.dump_sel, k);
      check("dump_data", b.dump_data, sat(m[k], 32));
      check("dump_data_w3", b3.dump_data, sat(m[k], 3));
      step();
    end
    dump_ready = 0;
    check("dump_exit", b.dump_valid, 0);
    check("dump_exit_rdy", b.in_ready, 1);
  endtask

  task automatic do_cmd(input vec_t v);
    int n = 0;
    bit ich = (v.cmd == 4'd2);
    while (!b.in_ready && n < 50) begin step(); n++; end
    check("in_ready_wait", b.in_ready, 1);
    check("in_ready_wait_w3", b3.in_ready, 1);
    in_valid = 1; in_cmd = v.cmd; in_addr = v.addr;
    step();
    in_valid = 0; in_cmd = 4'($urandom); in_addr = $urandom;
    if (v.cmd <= 4'd6) begin
      check("busy", b.in_ready, 0);
      for (int k = 0; k < v.rdy_lat; k++) begin
        chk_req(v);
        // responses while the request is still pending must be ignored
        d_rsp_valid = v.spur; i_rsp_valid = v.spur; d_rsp_hit = 1; i_rsp_hit = 1;
        step();
      end
      chk_req(v);
      if (ich) i_req_ready = 1; else d_req_ready = 1;
      step();
      d_req_ready = 0; i_req_ready = 0; d_rsp_valid = 0; i_rsp_valid = 0;
      check("req_drop_d", b.d_req_valid, 0);
      check("req_drop_i", b.i_req_valid, 0);
      for (int k = 0; k < v.rsp_lat; k++) begin
        // other channel's completion is not ours
        if (ich) d_rsp_valid = v.spur; else i_rsp_valid = v.spur;
        step();
      end
      d_rsp_valid = 0; i_rsp_valid = 0;
      if (ich) begin i_rsp_valid = 1; i_rsp_hit = v.hit; end
      else     begin d_rsp_valid = 1; d_rsp_hit = v.hit; end
      step();
      d_rsp_valid = 0; i_rsp_valid = 0;
      check("done_ready", b.in_ready, 1);
      case (v.cmd)
        4'd0: begin m[0]++; if (v.hit) m[2]++; else m[3]++; end
        4'd1: begin m[1]++; if (v.hit) m[2]++; else m[3]++; end
        4'd2: begin m[4]++; if (v.hit) m[5]++; else m[6]++; end
        default: ;
      endcase
    end else if (v.cmd == 4'd8) begin
      check("cache_clr", b.cache_clr, 1);
      check("cache_clr_w3", b3.cache_clr, 1);
      check("clr_busy", b.in_ready, 0);
      step();
      check("cache_clr_off", b.cache_clr, 0);
      check("clr_ready", b.in_ready, 1);
      model_clear();
    end else if (v.cmd == 4'd9) begin
      dump(v.tog);
    end else begin
      check("inv_ready", b.in_ready, 1);
      m[7]++;
    end
  endtask

  function automatic vec_t mk(input logic [3:0] cmd, input logic [31:0] addr,
                              input bit hit, input int rl, input int sl,
                              input bit spur, input bit tog);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.hit = hit; v.rdy_lat = rl; v.rsp_lat = sl;
    v.spur = spur; v.tog = tog;
    v.tag = addr[31:20]; v.idx = addr[19:6]; v.off = addr[5:0];
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    vec_t v;
    // {cmd, addr, tag, index, offset, hit, rdy_lat, rsp_lat, spur, tog}
    tbl[0] = '{4'd0, 32'h1234_5678, 12'h123, 14'h1159, 6'h38, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[1] = '{4'd2, 32'h0000_0040, 12'h000, 14'h0001, 6'h00, 1'b1, 1, 2, 1'b1, 1'b0};
    tbl[2] = '{4'd4, 32'hFFFF_FFFF, 12'hFFF, 14'h3FFF, 6'h3F, 1'b1, 2, 1, 1'b1, 1'b0};
    tbl[3] = '{4'd1, 32'hABCD_E0C1, 12'hABC, 14'h3783, 6'h01, 1'b1, 0, 3, 1'b0, 1'b0};
    tbl[4] = '{4'd7, 32'h0000_0000, 12'h000, 14'h0000, 6'h00, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[5] = '{4'd9, 32'h0000_0000, 12'h000, 14'h0000, 6'h00, 1'b0, 0, 0, 1'b0, 1'b0};
    model_clear();

    // reset values
    step(); step();
    check("rst_in_ready", b.in_ready, 1);
    check("rst_d_valid", b.d_req_valid, 0);
    check("rst_i_valid", b.i_req_valid, 0);
    check("rst_clr", b.cache_clr, 0);
    check("rst_dump_valid", b.dump_valid, 0);
    check("rst_dump_sel", b.dump_sel, 0);
    check("rst_dump_data", b.dump_data, 0);
    check("rst_d_tag", b.d_req_tag, 0);
    check("rst_i_index", b.i_req_index, 0);
    @(negedge clk); rst_n = 1;
    step();

    // table of address splits, routing, invalid command and a dump
    for (int i = 0; i < 6; i++) do_cmd(tbl[i]);

    // reset while a data request is pending
    in_valid = 1; in_cmd = 4'd0; in_addr = 32'h55; step(); in_valid = 0;
    check("pre_rst_valid", b.d_req_valid, 1);
    rst_n = 0; #1;
    check("async_rst_valid", b.d_req_valid, 0);
    check("async_rst_valid_w3", b3.d_req_valid, 0);
    check("async_rst_ready", b.in_ready, 1);
    model_clear();
    @(negedge clk); rst_n = 1;
    d_rsp_valid = 1; d_rsp_hit = 1; step(); d_rsp_valid = 0;

    // 1,1,0 hits (one under a long stall with stray responses), 7, 12, toggled dump
    do_cmd(mk(4'd1, 32'h0000_1000, 1'b1, 20, 2, 1'b1, 1'b0));
    do_cmd(mk(4'd1, 32'h0000_2000, 1'b1, 0, 0, 1'b0, 1'b0));
    do_cmd(mk(4'd0, 32'h0000_3000, 1'b1, 0, 0, 1'b0, 1'b0));
    do_cmd(mk(4'd7, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0));
    do_cmd(mk(4'd12, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0));
    check("seq_model_rd", m[0], 1);
    check("seq_model_err", m[7], 2);
    do_cmd(mk(4'd9, 32'h0, 1'b0, 0, 0, 1'b0, 1'b1));

    // eight back-to-back read hits saturate the 3-bit instance, then clear
    for (int i = 0; i < 8; i++) do_cmd(mk(4'd0, $urandom, 1'b1, 0, 0, 1'b0, 1'b0));
    do_cmd(mk(4'd9, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0));
    do_cmd(mk(4'd8, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0));
    do_cmd(mk(4'd9, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0));

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [3:0] c = 4'($urandom_range(0, 15));
      if (c == 4'd8 && $urandom_range(0, 3) != 0) c = 4'd2;
      v = mk(c, $urandom, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 3),
             1'($urandom), 1'($urandom));
      do_cmd(v);
    end
    do_cmd(mk(4'd9, 32'h0, 1'b0, 0, 0, 1'b0, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
